prime_sweep_driver: RTL
=======================

Name: prime_sweep_driver

Overview:
Requester-side controller for the team's 10-bit prime checker handshake (input_no/input_valid in, result_ready/is_prime out).
- Given an inclusive range [range_lo, range_hi], issues each number to a checker one at a time.
- Waits for each result and streams out the primes found, with a running count.
- Sits between a host/test controller and one checker instance; holds a watchdog against a hung checker.

Parameters:
WIDTH, 10, width of numbers under test (matches checker input_no)
CNT_W, 8, width of prime_count (172 primes below 1024; saturates)
TIMEOUT, 255, max cycles to wait for check_ready per request before aborting

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sweep; ignored while busy
range_lo  input  WIDTH  first number to test, sampled with start
range_hi  input  WIDTH  last number to test (inclusive), sampled with start
busy  output  1  high from cycle after accepted start until done pulse
done  output  1  one-cycle pulse: sweep finished (normally or by timeout)
timeout_err  output  1  sticky; set on watchdog abort, cleared by next accepted start
prime_valid  output  1  one-cycle pulse: prime_no is a prime
prime_no  output  WIDTH  prime found; valid with prime_valid
prime_count  output  CNT_W  primes found this sweep; saturating; held after done
check_no  output  WIDTH  number presented to checker (drives input_no)
check_valid  output  1  one-cycle request pulse to checker (drives input_valid)
check_ready  input  1  checker result_ready (one-cycle pulse)
check_is_prime  input  1  checker is_prime, qualified by check_ready

Behaviour:
- Reset (async, reset_n low):
  - all outputs 0; state IDLE; internal cur/hi/timer cleared.
  - Reset mid-sweep abandons the sweep; no done pulse.
- All outputs are registered.
- States IDLE, ISSUE, WAIT, FINISH.
- IDLE:
  - start=1 latches range_lo→cur and range_hi→hi.
  - Clears prime_count and timeout_err; busy←1.
  - If range_lo > range_hi → FINISH (no checker requests); else → ISSUE.
- ISSUE:
  - check_valid=1 and check_no=cur for exactly this one cycle (first request is one cycle after start is sampled).
  - Timer cleared; → WAIT.
- WAIT:
  - Timer increments each cycle.
  - On check_ready=1:
    - If check_is_prime: prime_valid pulses the next cycle with prime_no=cur, and prime_count increments, saturating at 2^CNT_W-1.
    - Then if cur==hi → FINISH; else cur←cur+1 → ISSUE.
  - If timer reaches TIMEOUT-1 with no check_ready → timeout_err←1, → FINISH.
- FINISH: done=1 for one cycle, busy←0, → IDLE.
- Back-to-back requests:
  - ISSUE always follows the cycle in which check_ready was sampled.
  - This guarantees check_valid is never held high and the checker is back in its idle state when requested.
- check_ready outside WAIT is ignored, including during the ISSUE cycle itself.
- Wrap-around: termination compares cur==hi before incrementing, so range_hi=2^WIDTH-1 never wraps cur to 0.
- check_no holds its last value when check_valid is low.
- start during busy is ignored; range inputs are not re-sampled.
- start in the same cycle as FINISH is ignored; it is accepted only in IDLE.
- Single-number range (lo==hi) issues exactly one request.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ISSUE, WAIT, FINISH) and default WIDTH/CNT_W constants, so the checker and driver agree on number width;
  - TIMEOUT default.
- One natural sub-module: prime_sweep_timer, a clearable, enabled counter with terminal-count flag at TIMEOUT-1.
- Everything else stays flat in the FSM.

Test Plan:
- range 10..20 with the real checker attached → prime_no pulses 11,13,17,19 in order; prime_count=4; one done pulse; timeout_err=0; exactly 11 check_valid pulses.
- range_lo=30, range_hi=20 → done two cycles after start; zero check_valid pulses; prime_count=0.
- range 1020..1023 → single prime 1021; prime_count=1; last check_no=1023; no request for 0 after it (no wrap).
- range 0..3 → requests 0,1,2,3; primes 2,3; prime_count=2; check_valid never high two consecutive cycles.
- Behavioural checker model that never raises ready, range 5..9 → one check_valid (check_no=5); after TIMEOUT cycles timeout_err=1 and done pulses; next start clears timeout_err.
- Assert reset_n low mid-sweep in WAIT (range 100..200) → all outputs 0 immediately, no done. After release, start with 7..7 → prime_no=7, count=1, done. A start pulsed while busy has no effect.

Source files
------------

// File: rtl/prime_sweep_driver_pkg.sv
// Shared types and defaults for the prime sweep driver.
// Keeps the checker and driver in agreement on number width.
package prime_sweep_driver_pkg;

  localparam int WIDTH_DEF   = 10;
  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

endpackage

// File: rtl/prime_sweep_driver_if.sv
// Request/response handshake between the sweep driver
// and a single prime checker instance.
interface prime_sweep_driver_if
  import prime_sweep_driver_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] check_no;
  logic             check_valid;
  logic             check_ready;
  logic             check_is_prime;

  modport master (
    output check_no,
    output check_valid,
    input  check_ready,
    input  check_is_prime
  );

  modport slave (
    input  check_no,
    input  check_valid,
    output check_ready,
    output check_is_prime
  );

endinterface

// File: rtl/prime_sweep_timer.sv
// Watchdog counter: clear, count when enabled,
// flag when the count sits at TIMEOUT-1.
module prime_sweep_timer
  import prime_sweep_driver_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] cnt;

  // count register; clear wins over enable
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/prime_sweep_driver.sv
// Walks an inclusive range through one prime checker,
// streaming primes found with a running count.
module prime_sweep_driver
  import prime_sweep_driver_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] range_lo,
  input  logic [WIDTH-1:0] range_hi,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             prime_valid,
  output logic [WIDTH-1:0] prime_no,
  output logic [CNT_W-1:0] prime_count,
  prime_sweep_driver_if.master chk
);

  state_t           state, state_n;
  logic [WIDTH-1:0] cur, cur_n;
  logic [WIDTH-1:0] hi, hi_n;
  logic             busy_n, done_n, terr_n, pv_n;
  logic [WIDTH-1:0] pno_n;
  logic [CNT_W-1:0] cnt_n;
  logic [WIDTH-1:0] cno_q, cno_n;
  logic             cv_q, cv_n;
  logic             tmr_clr, tmr_en, tmr_tc;

  prime_sweep_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmr_clr),
    .en      (tmr_en),
    .tc      (tmr_tc)
  );

  assign chk.check_no    = cno_q;
  assign chk.check_valid = cv_q;

  // next-state and registered-output decode
  always_comb begin
    state_n = state;
    cur_n   = cur;
    hi_n    = hi;
    busy_n  = busy;
    done_n  = 1'b0;
    terr_n  = timeout_err;
    pv_n    = 1'b0;
    pno_n   = prime_no;
    cnt_n   = prime_count;
    cno_n   = cno_q;
    cv_n    = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          cur_n  = range_lo;
          hi_n   = range_hi;
          cnt_n  = '0;
          terr_n = 1'b0;
          busy_n = 1'b1;
          if (range_lo > range_hi) begin
            state_n = FINISH;
          end else begin
            state_n = ISSUE;
            cv_n    = 1'b1;
            cno_n   = range_lo;
          end
        end
      end
      ISSUE: begin
        tmr_clr = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        tmr_en = 1'b1;
        if (chk.check_ready) begin
          if (chk.check_is_prime) begin
            pv_n  = 1'b1;
            pno_n = cur;
            if (prime_count != '1) begin
              cnt_n = prime_count + 1'b1;
            end
          end
          // compare before increment so hi=max never wraps
          if (cur == hi) begin
            state_n = FINISH;
          end else begin
            cur_n   = cur + 1'b1;
            state_n = ISSUE;
            cv_n    = 1'b1;
            cno_n   = cur + 1'b1;
          end
        end else if (tmr_tc) begin
          terr_n  = 1'b1;
          state_n = FINISH;
        end
      end
      FINISH: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur         <= '0;
      hi          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      prime_valid <= 1'b0;
      prime_no    <= '0;
      prime_count <= '0;
      cno_q       <= '0;
      cv_q        <= 1'b0;
    end else begin
      state       <= state_n;
      cur         <= cur_n;
      hi          <= hi_n;
      busy        <= busy_n;
      done        <= done_n;
      timeout_err <= terr_n;
      prime_valid <= pv_n;
      prime_no    <= pno_n;
      prime_count <= cnt_n;
      cno_q       <= cno_n;
      cv_q        <= cv_n;
    end
  end

endmodule
